// File: rtl/memory_pkg.sv
// memory_pkg: types shared by the memory arbiter and its requesters.
//   mem_read_req      : fetch/load request (valid, addr, size)
//   mem_write_req     : store request (valid, addr, size, strobe, data)
//   mem_arb_resp_t    : response toward a requester or from the bus (data_ok, data)
//   mem_arb_bus_req_t : request driven onto the shared bus
//   mem_arb_state_t   : arbiter state encoding (IDLE, BUSY_I, BUSY_D)
package memory_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [1:0]  size;
  } mem_read_req;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } mem_write_req;

  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } mem_arb_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } mem_arb_bus_req_t;

  typedef logic [1:0] mem_arb_state_t;

  localparam mem_arb_state_t IDLE   = 2'd0;
  localparam mem_arb_state_t BUSY_I = 2'd1;
  localparam mem_arb_state_t BUSY_D = 2'd2;

  // Reads carry no strobe and no write data on the bus.
  function automatic mem_arb_bus_req_t bus_from_read(mem_read_req r);
    mem_arb_bus_req_t b;
    b          = '0;
    b.valid    = 1'b1;
    b.is_write = 1'b0;
    b.addr     = r.addr;
    b.size     = r.size;
    return b;
  endfunction

  function automatic mem_arb_bus_req_t bus_from_write(mem_write_req w);
    mem_arb_bus_req_t b;
    b          = '0;
    b.valid    = 1'b1;
    b.is_write = 1'b1;
    b.addr     = w.addr;
    b.size     = w.size;
    b.strobe   = w.strobe;
    b.data     = w.data;
    return b;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the requester-side and bus-side signals of the arbiter.
//   ireq/iresp          : fetch request / response
//   dread/dwrite/dresp  : memory-stage load, store / response
//   breq/bresp          : shared bus request / response
// Modports: master = arbiter side, slave = requesters and bus model side.
interface mem_arbiter_if;
  import memory_pkg::*;

  mem_read_req      ireq;
  mem_arb_resp_t    iresp;
  mem_read_req      dread;
  mem_write_req     dwrite;
  mem_arb_resp_t    dresp;
  mem_arb_bus_req_t breq;
  mem_arb_resp_t    bresp;

  modport master (
    input  ireq, dread, dwrite, bresp,
    output iresp, dresp, breq
  );

  modport slave (
    output ireq, dread, dwrite, bresp,
    input  iresp, dresp, breq
  );
endinterface

// File: rtl/mem_arb_starve.sv
// mem_arb_starve: counts consecutive D-side grants made while a fetch waits.
//   clk, resetn : clock, asynchronous active-low reset
//   grant_d     : D-side grant this cycle
//   grant_i     : I-side grant this cycle
//   ireq_valid  : fetch request pending at the grant
//   force_i     : next IDLE grant must go to the I side
// Built only when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arb_starve #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic grant_d,
  input  logic grant_i,
  input  logic ireq_valid,
  output logic force_i
);

  localparam int CW = ($clog2(STARVE_MAX + 1) > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [CW-1:0] count_reg;

  // A D grant with no fetch waiting breaks the streak. The count never
  // passes STARVE_MAX: at the limit either I wins or the streak breaks.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_reg <= '0;
    end else if (grant_i) begin
      count_reg <= '0;
    end else if (grant_d) begin
      count_reg <= ireq_valid ? count_reg + 1'b1 : '0;
    end
  end

  assign force_i = (count_reg == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch I, memory-stage D) arbiter onto one bus,
// one transaction outstanding at a time.
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : mem_arbiter_if.master (ireq, dread, dwrite in; iresp, dresp out;
//            breq out, bresp in)
// Optional feature: MEM_ARB_STARVE_GUARD_EN enables the fetch starvation guard
// (STARVE_MAX consecutive D grants while I waits, then I is granted).
module mem_arbiter
  import memory_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         resetn,
  mem_arbiter_if.master bus
);

  mem_arb_state_t   state_reg, state_next;
  mem_arb_bus_req_t lat_reg, lat_next;
  logic             idle;
  logic             d_pending;
  logic             grant_i;
  logic             grant_d;
  logic             force_i;

  assign idle      = (state_reg == IDLE);
  assign d_pending = bus.dread.valid | bus.dwrite.valid;
  assign grant_i   = idle & bus.ireq.valid & (force_i | ~d_pending);
  assign grant_d   = idle & d_pending & ~grant_i;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .resetn    (resetn),
    .grant_d   (grant_d),
    .grant_i   (grant_i),
    .ireq_valid(bus.ireq.valid),
    .force_i   (force_i)
  );
`else
  assign force_i = 1'b0;
  localparam int unused_starve_max = STARVE_MAX;
`endif

  always_comb begin
    state_next = state_reg;
    lat_next   = lat_reg;
    case (state_reg)
      IDLE: begin
        if (grant_d) begin
          state_next = BUSY_D;
          // A simultaneous load and store is illegal; the store wins.
          lat_next = bus.dwrite.valid ? bus_from_write(bus.dwrite)
                                      : bus_from_read(bus.dread);
        end else if (grant_i) begin
          state_next = BUSY_I;
          lat_next   = bus_from_read(bus.ireq);
        end
      end
      BUSY_I, BUSY_D: begin
        // Only valid drops on completion; the other fields stay as last issued.
        if (bus.bresp.data_ok) begin
          state_next     = IDLE;
          lat_next.valid = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      lat_reg   <= '0;
    end else begin
      state_reg <= state_next;
      lat_reg   <= lat_next;
    end
  end

  // lat_reg.valid is set exactly while BUSY, so it is the bus valid.
  assign bus.breq = lat_reg;

  // Bus response goes straight through to the current owner.
  always_comb begin
    bus.iresp = '0;
    bus.dresp = '0;
    if (state_reg == BUSY_I) begin
      bus.iresp = bus.bresp;
    end else if (state_reg == BUSY_D) begin
      bus.dresp = bus.bresp;
    end
  end

  a_d_exclusive: assert property (@(posedge clk) disable iff (!resetn)
    !(bus.dread.valid && bus.dwrite.valid));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter (directed scenarios plus
// a randomized run against a transaction-level grant model).
module tb_mem_arbiter;
  import memory_pkg::*;

  localparam int SM = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_MAX(SM)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.ireq   = '0;
    bus.dread  = '0;
    bus.dwrite = '0;
    bus.bresp  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn    = 1'b0;
    bus.ireq  = '{1'b1, 32'h1000_0000, 2'd2};
    bus.bresp = '{1'b1, 32'h1234_5678};
    tick();
    tick();
    mid();
    n_cmp++; if (bus.breq.valid !== 1'b0) begin n_bad++; $display("FAIL rst_breq_valid got=%b want=0", bus.breq.valid); end
    n_cmp++; if (bus.breq !== '0) begin n_bad++; $display("FAIL rst_latched got=%h want=0", bus.breq); end
    n_cmp++; if (bus.iresp.data_ok !== 1'b0 || bus.dresp.data_ok !== 1'b0) begin n_bad++; $display("FAIL rst_resp got i=%b d=%b want 0/0", bus.iresp.data_ok, bus.dresp.data_ok); end
    bus.bresp = '0;
    tick();
    resetn = 1'b1;
    mid();
    n_cmp++; if (bus.breq.valid !== 1'b0) begin n_bad++; $display("FAIL rst_no_early_grant got=%b want=0", bus.breq.valid); end
    tick();
    mid();
    n_cmp++; if (bus.breq.valid !== 1'b1 || bus.breq.addr !== 32'h1000_0000) begin n_bad++; $display("FAIL rst_first_grant got v=%b a=%h want v=1 a=10000000", bus.breq.valid, bus.breq.addr); end
    bus.bresp = '{1'b1, 32'h0000_0011};
    #1;
    n_cmp++; if (bus.iresp !== '{1'b1, 32'h0000_0011}) begin n_bad++; $display("FAIL rst_first_resp got=%h want=100000011", bus.iresp); end
    tick();
    clear_inputs();
    $display("txn reset: fetch 10000000 granted on first edge after release");
  endtask

  task automatic test_fetch_alone();
    bus.ireq = '{1'b1, 32'hBFC0_0000, 2'd2};
    tick();
    mid();
    n_cmp++; if (bus.breq !== '{1'b1, 1'b0, 32'hBFC0_0000, 2'd2, 4'h0, 32'h0}) begin n_bad++; $display("FAIL fetch_breq got=%h want addr bfc00000 read", bus.breq); end
    n_cmp++; if (bus.iresp.data_ok !== 1'b0) begin n_bad++; $display("FAIL fetch_early_ok got=%b want=0", bus.iresp.data_ok); end
    tick();
    bus.bresp = '{1'b1, 32'h3C08_0001};
    mid();
    n_cmp++; if (bus.iresp !== '{1'b1, 32'h3C08_0001}) begin n_bad++; $display("FAIL fetch_iresp got=%h want=13c080001", bus.iresp); end
    n_cmp++; if (bus.dresp.data_ok !== 1'b0) begin n_bad++; $display("FAIL fetch_dresp got=%b want=0", bus.dresp.data_ok); end
    tick();
    bus.bresp = '0;
    bus.ireq  = '0;
    mid();
    n_cmp++; if (bus.breq.valid !== 1'b0 || bus.iresp.data_ok !== 1'b0) begin n_bad++; $display("FAIL fetch_idle got v=%b ok=%b want 0/0", bus.breq.valid, bus.iresp.data_ok); end
    tick();
    $display("txn fetch: bfc00000 -> 3c080001");
  endtask

  task automatic test_conflict();
    bus.ireq  = '{1'b1, 32'hBFC0_0004, 2'd2};
    bus.dread = '{1'b1, 32'h8000_1000, 2'd2};
    tick();
    mid();
    n_cmp++; if (bus.breq.addr !== 32'h8000_1000 || bus.breq.valid !== 1'b1) begin n_bad++; $display("FAIL conflict_d_first got a=%h v=%b want 80001000/1", bus.breq.addr, bus.breq.valid); end
    bus.bresp = '{1'b1, 32'h5555_AAAA};
    #1;
    n_cmp++; if (bus.dresp !== '{1'b1, 32'h5555_AAAA} || bus.iresp.data_ok !== 1'b0) begin n_bad++; $display("FAIL conflict_dresp got d=%h i_ok=%b want 15555aaaa/0", bus.dresp, bus.iresp.data_ok); end
    tick();
    bus.bresp = '0;
    bus.dread = '0;
    mid();
    n_cmp++; if (bus.breq.valid !== 1'b0) begin n_bad++; $display("FAIL conflict_idle got=%b want=0", bus.breq.valid); end
    tick();
    mid();
    n_cmp++; if (bus.breq.addr !== 32'hBFC0_0004 || bus.breq.valid !== 1'b1) begin n_bad++; $display("FAIL conflict_i_next got a=%h v=%b want bfc00004/1", bus.breq.addr, bus.breq.valid); end
    bus.bresp = '{1'b1, 32'h0000_0042};
    #1;
    n_cmp++; if (bus.iresp !== '{1'b1, 32'h0000_0042}) begin n_bad++; $display("FAIL conflict_iresp got=%h want=100000042", bus.iresp); end
    tick();
    clear_inputs();
    $display("txn conflict: D 80001000 then I bfc00004");
  endtask

  task automatic test_store();
    bus.dwrite = '{1'b1, 32'h8000_0003, 2'd0, 4'b1000, 32'hAB00_0000};
    tick();
    mid();
    n_cmp++; if (bus.breq !== '{1'b1, 1'b1, 32'h8000_0003, 2'd0, 4'b1000, 32'hAB00_0000}) begin n_bad++; $display("FAIL store_breq got=%h want sb 80000003 s=8 d=ab000000", bus.breq); end
    n_cmp++; if (bus.dresp.data_ok !== 1'b0) begin n_bad++; $display("FAIL store_early_ok got=%b want=0", bus.dresp.data_ok); end
    bus.bresp = '{1'b1, 32'h0};
    #1;
    n_cmp++; if (bus.dresp.data_ok !== 1'b1 || bus.iresp.data_ok !== 1'b0) begin n_bad++; $display("FAIL store_dresp got d=%b i=%b want 1/0", bus.dresp.data_ok, bus.iresp.data_ok); end
    tick();
    clear_inputs();
    $display("txn store: sb 80000003 strobe 1000 data ab000000");
  endtask

  task automatic test_idle_bresp();
    clear_inputs();
    bus.bresp = '{1'b1, 32'hDEAD_BEEF};
    mid();
    n_cmp++; if (bus.iresp.data_ok !== 1'b0 || bus.dresp.data_ok !== 1'b0) begin n_bad++; $display("FAIL idle_bresp_resp got i=%b d=%b want 0/0", bus.iresp.data_ok, bus.dresp.data_ok); end
    tick();
    mid();
    n_cmp++; if (bus.breq.valid !== 1'b0) begin n_bad++; $display("FAIL idle_bresp_state got=%b want=0", bus.breq.valid); end
    bus.bresp = '0;
    bus.ireq  = '{1'b1, 32'hBFC0_0008, 2'd2};
    tick();
    mid();
    n_cmp++; if (bus.breq.valid !== 1'b1 || bus.breq.addr !== 32'hBFC0_0008) begin n_bad++; $display("FAIL idle_bresp_after got v=%b a=%h want 1/bfc00008", bus.breq.valid, bus.breq.addr); end
    bus.bresp = '{1'b1, 32'h7};
    tick();
    clear_inputs();
    $display("txn idle_bresp: ignored, then fetch bfc00008");
  endtask

  task automatic test_reset_midop();
    bus.dread = '{1'b1, 32'h8000_0040, 2'd2};
    tick();
    mid();
    n_cmp++; if (bus.breq.valid !== 1'b1) begin n_bad++; $display("FAIL midrst_busy got=%b want=1", bus.breq.valid); end
    resetn = 1'b0;
    #1;
    n_cmp++; if (bus.breq.valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got=%b want=0", bus.breq.valid); end
    clear_inputs();
    tick();
    resetn    = 1'b1;
    bus.bresp = '{1'b1, 32'h0BAD_0BAD};
    mid();
    n_cmp++; if (bus.iresp.data_ok !== 1'b0 || bus.dresp.data_ok !== 1'b0) begin n_bad++; $display("FAIL midrst_late got i=%b d=%b want 0/0", bus.iresp.data_ok, bus.dresp.data_ok); end
    tick();
    bus.bresp = '0;
    mid();
    n_cmp++; if (bus.breq.valid !== 1'b0) begin n_bad++; $display("FAIL midrst_idle got=%b want=0", bus.breq.valid); end
    tick();
    $display("txn reset_midop: D 80000040 abandoned");
  endtask

  task automatic test_starve();
    string exp_order;
    byte   want;
    byte   got;
`ifdef MEM_ARB_STARVE_GUARD_EN
    exp_order = "DDIDDI";
`else
    exp_order = "DDDDDD";
`endif
    do_reset();
    bus.ireq = '{1'b1, 32'hBFC0_0100, 2'd2};
    for (int g = 0; g < 6; g++) begin
      bus.dread = '{1'b1, 32'h8000_2000 + 32'(g * 4), 2'd2};
      tick();
      mid();
      want = exp_order[g];
      got  = (bus.breq.addr == 32'hBFC0_0100) ? "I" : "D";
      n_cmp++; if (bus.breq.valid !== 1'b1 || got != want) begin n_bad++; $display("FAIL starve_grant%0d got=%s v=%b want=%s", g, got, bus.breq.valid, want); end
      bus.bresp = '{1'b1, 32'(g)};
      tick();
      bus.bresp = '0;
      $display("txn starve %0d: grant %s", g, got);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random(int n);
    bit               ia;
    bit               da;
    bit               dw;
    bit               own_d;
    mem_read_req      ir;
    mem_read_req      dr;
    mem_write_req     wr;
    mem_arb_bus_req_t exp;
    mem_arb_resp_t    got;
    logic [31:0]      rdata;
    int               w;
`ifdef MEM_ARB_STARVE_GUARD_EN
    int               streak;
    streak = 0;
`endif
    ia = 1'b0; da = 1'b0; dw = 1'b0;
    ir = '0; dr = '0; wr = '0;
    do_reset();
    for (int t = 0; t < n; t++) begin
      if (!ia && $urandom_range(0, 2) != 0) begin
        ia = 1'b1;
        ir = '{1'b1, $urandom(), 2'($urandom_range(0, 2))};
      end
      if (!da && $urandom_range(0, 2) != 0) begin
        da = 1'b1;
        dw = ($urandom_range(0, 1) == 1);
        dr = '{1'b1, $urandom(), 2'($urandom_range(0, 2))};
        wr = '{1'b1, $urandom(), 2'($urandom_range(0, 2)), 4'($urandom_range(1, 15)), $urandom()};
      end
      bus.ireq   = ia ? ir : '0;
      bus.dread  = (da && !dw) ? dr : '0;
      bus.dwrite = (da && dw) ? wr : '0;
      if (!ia && !da) begin
        mid();
        n_cmp++; if (bus.breq.valid !== 1'b0) begin n_bad++; $display("FAIL rnd_idle%0d got=%b want=0", t, bus.breq.valid); end
        tick();
        continue;
      end
`ifdef MEM_ARB_STARVE_GUARD_EN
      own_d = da && !(ia && streak == SM);
      if (own_d) streak = ia ? streak + 1 : 0;
      else       streak = 0;
`else
      own_d = da;
`endif
      if (own_d && dw)  exp = '{1'b1, 1'b1, wr.addr, wr.size, wr.strobe, wr.data};
      else if (own_d)   exp = '{1'b1, 1'b0, dr.addr, dr.size, 4'h0, 32'h0};
      else              exp = '{1'b1, 1'b0, ir.addr, ir.size, 4'h0, 32'h0};
      tick();
      // Owner may withdraw after the grant; the transaction must still finish.
      if ($urandom_range(0, 3) == 0) begin
        if (own_d) begin
          bus.dread  = '{1'b0, $urandom(), 2'd1};
          bus.dwrite = '0;
          da = 1'b0;
        end else begin
          bus.ireq = '{1'b0, $urandom(), 2'd1};
          ia = 1'b0;
        end
      end
      w = $urandom_range(0, 2);
      repeat (w) begin
        mid();
        n_cmp++; if (bus.breq !== exp) begin n_bad++; $display("FAIL rnd_wait_breq%0d got=%h want=%h", t, bus.breq, exp); end
        n_cmp++; if (bus.iresp.data_ok !== 1'b0 || bus.dresp.data_ok !== 1'b0) begin n_bad++; $display("FAIL rnd_wait_ok%0d got i=%b d=%b want 0/0", t, bus.iresp.data_ok, bus.dresp.data_ok); end
        tick();
      end
      rdata     = $urandom();
      bus.bresp = '{1'b1, rdata};
      mid();
      got = own_d ? bus.dresp : bus.iresp;
      n_cmp++; if (bus.breq !== exp) begin n_bad++; $display("FAIL rnd_breq%0d got=%h want=%h", t, bus.breq, exp); end
      n_cmp++; if (got !== '{1'b1, rdata}) begin n_bad++; $display("FAIL rnd_resp%0d got=%h want=1%h", t, got, rdata); end
      n_cmp++; if ((own_d ? bus.iresp.data_ok : bus.dresp.data_ok) !== 1'b0) begin n_bad++; $display("FAIL rnd_other%0d got=1 want=0", t); end
      tick();
      bus.bresp = '0;
      if (own_d) da = 1'b0;
      else       ia = 1'b0;
      $display("txn rnd %0d: %s addr=%h wr=%b wait=%0d data=%h", t, own_d ? "D" : "I", exp.addr, exp.is_write, w, rdata);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_fetch_alone();
    test_conflict();
    test_store();
    test_idle_bresp();
    test_reset_midop();
    test_starve();
    test_random(60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
